// File: rtl/fcs_mpc_sample_rx.sv
// Purpose : synchronise, debounce, decimate and frame the iL/vg/vc sensor buses into samples.
// Latency : pad change to smp_valid is 2 sync + STABLE_CYCLES + 1 capture cycles once a request is pending.
// Backpr. : a capture while smp_valid=1 and smp_ready=0 drops the new sample and bumps overrun_cnt.
//
// Ports:
//   wb_clk_i, wb_rst_i      clock, synchronous active-high reset
//   en                      block enable; low parks the FSM in IDLE and holds the period counter at 0
//   il_pad/vg_pad/vc_pad    raw asynchronous 8-bit measurement buses
//   smp_valid/smp_ready     sample handshake; il_out/vg_out/vc_out carry the sample
//   overrun_cnt             saturating count of dropped samples
//   busy                    a sample request is pending (waiting for the word to settle)
//   range_err               only with FCS_MPC_SAMPLE_RANGE_CHECK_EN: captured iL/vc code outside 1..IL_MAX / 1..VC_MAX
module fcs_mpc_sample_rx #(
    parameter int unsigned SAMPLE_DIV    = 16,
    parameter int unsigned STABLE_CYCLES = 4
`ifdef FCS_MPC_SAMPLE_RANGE_CHECK_EN
    ,
    parameter logic [7:0]  IL_MAX        = 8'd7,
    parameter logic [7:0]  VC_MAX        = 8'd6
`endif
) (
    input  logic       wb_clk_i,
    input  logic       wb_rst_i,
    input  logic       en,
    input  logic [7:0] il_pad,
    input  logic [7:0] vg_pad,
    input  logic [7:0] vc_pad,
    output logic       smp_valid,
    input  logic       smp_ready,
    output logic [7:0] il_out,
    output logic [7:0] vg_out,
    output logic [7:0] vc_out,
    output logic [7:0] overrun_cnt,
    output logic       busy
`ifdef FCS_MPC_SAMPLE_RANGE_CHECK_EN
    ,
    output logic       range_err
`endif
);

    localparam logic [7:0]  STAB_MAX = 8'(STABLE_CYCLES);
    localparam logic [15:0] DIV_LAST = 16'(SAMPLE_DIV - 1);

    typedef enum logic [1:0] {
        IDLE,
        WAIT_TICK,
        WAIT_STABLE
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic [23:0] sync1;
    logic [23:0] word;      // {vc, vg, il} after the second synchroniser stage
    logic [23:0] word_d;
    logic [7:0]  stab;
    logic [15:0] period_cnt;
    logic        stable;
    logic        tick;
    logic        capture;
    logic        load;

    // Synchroniser and debounce: stab counts consecutive cycles the word held still.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            sync1  <= '0;
            word   <= '0;
            word_d <= '0;
            stab   <= '0;
        end else begin
            sync1  <= {vc_pad, vg_pad, il_pad};
            word   <= sync1;
            word_d <= word;
            if (word != word_d) begin
                stab <= '0;
            end else if (stab != STAB_MAX) begin
                stab <= stab + 8'd1;
            end
        end
    end

    assign stable = (stab == STAB_MAX);

    // Decimation counter; held at 0 while disabled so the first tick lands SAMPLE_DIV cycles after enable.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i || !en) begin
            period_cnt <= '0;
        end else if (tick) begin
            period_cnt <= '0;
        end else begin
            period_cnt <= period_cnt + 16'd1;
        end
    end

    assign tick = (period_cnt == DIV_LAST);

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Ticks seen in WAIT_STABLE are ignored, so at most one request is ever outstanding.
    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        capture   = 1'b0;
        case (state)
            IDLE: begin
                state_nxt = WAIT_TICK;
            end
            WAIT_TICK: begin
                if (tick) begin
                    state_nxt = WAIT_STABLE;
                end
            end
            WAIT_STABLE: begin
                busy = 1'b1;
                if (stable) begin
                    capture   = 1'b1;
                    state_nxt = WAIT_TICK;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
        // Disabling abandons a pending request but leaves any held sample in place.
        if (!en) begin
            state_nxt = IDLE;
            capture   = 1'b0;
        end
    end

    // A capture may reuse the slot being handed off this cycle, giving back-to-back samples.
    assign load = capture && (!smp_valid || smp_ready);

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            smp_valid   <= 1'b0;
            il_out      <= '0;
            vg_out      <= '0;
            vc_out      <= '0;
            overrun_cnt <= '0;
`ifdef FCS_MPC_SAMPLE_RANGE_CHECK_EN
            range_err   <= 1'b0;
`endif
        end else if (load) begin
            smp_valid <= 1'b1;
            il_out    <= word[7:0];
            vg_out    <= word[15:8];
            vc_out    <= word[23:16];
`ifdef FCS_MPC_SAMPLE_RANGE_CHECK_EN
            range_err <= (word[7:0] > IL_MAX) || (word[7:0] == 8'd0) ||
                         (word[23:16] > VC_MAX) || (word[23:16] == 8'd0);
`endif
        end else begin
            // Capture without load means the consumer is stalled: drop and count.
            if (capture && (overrun_cnt != 8'hFF)) begin
                overrun_cnt <= overrun_cnt + 8'd1;
            end
            if (smp_valid && smp_ready) begin
                smp_valid <= 1'b0;
`ifdef FCS_MPC_SAMPLE_RANGE_CHECK_EN
                range_err <= 1'b0;
`endif
            end
        end
    end

endmodule

// File: tb/tb_fcs_mpc_sample_rx.sv
module tb_fcs_mpc_sample_rx;

    localparam int DIV  = 16;
    localparam int S    = 4;
    localparam int HLEN = 16384;

    logic       clk    = 1'b0;
    logic       rst    = 1'b1;
    logic       en     = 1'b0;
    logic       rdy    = 1'b0;
    logic [7:0] il_pad = 8'd0;
    logic [7:0] vg_pad = 8'd0;
    logic [7:0] vc_pad = 8'd0;
    logic       smp_valid;
    logic       busy;
    logic [7:0] il_out;
    logic [7:0] vg_out;
    logic [7:0] vc_out;
    logic [7:0] overrun_cnt;
`ifdef FCS_MPC_SAMPLE_RANGE_CHECK_EN
    logic       range_err;
`endif

    int total = 0;
    int bad   = 0;
    bit chk_en = 1'b0;

    always #5 clk = ~clk;

    fcs_mpc_sample_rx dut (
        .wb_clk_i    (clk),
        .wb_rst_i    (rst),
        .en          (en),
        .il_pad      (il_pad),
        .vg_pad      (vg_pad),
        .vc_pad      (vc_pad),
        .smp_valid   (smp_valid),
        .smp_ready   (rdy),
        .il_out      (il_out),
        .vg_out      (vg_out),
        .vc_out      (vc_out),
        .overrun_cnt (overrun_cnt),
        .busy        (busy)
`ifdef FCS_MPC_SAMPLE_RANGE_CHECK_EN
        ,
        .range_err   (range_err)
`endif
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Pad values are kept per edge since the last reset; pad(k<=0) reads as 0 (flops cleared).
    // The synchronised word after edge n is pad(n-1); it counts as settled after edge n when
    // pad(n-2-S .. n-2) are all equal and at least S edges have passed since reset.
    logic [23:0] padh [0:HLEN-1];
    int   n       = 0;
    int   en_len  = 0;      // consecutive enabled edges; period position = en_len mod DIV
    bit   m_active  = 1'b0; // FSM out of IDLE
    bit   m_pending = 1'b0; // request waiting for a settled word
    bit   m_valid   = 1'b0;
    logic [7:0] m_il = 8'd0, m_vg = 8'd0, m_vc = 8'd0, m_ovr = 8'd0;
    bit   m_rerr    = 1'b0;
    bit   m_stb, m_tck, m_cap;
    logic [23:0] m_w;

    function automatic logic [23:0] pad_at(input int k);
        return (k <= 0) ? 24'd0 : padh[k % HLEN];
    endfunction

    function automatic bit settled_after(input int nn);
        if (nn < S) return 1'b0;
        for (int m = nn - 2 - S; m < nn - 2; m++)
            if (pad_at(m) != pad_at(m + 1)) return 1'b0;
        return 1'b1;
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            n = 0; en_len = 0; m_active = 0; m_pending = 0; m_valid = 0;
            m_il = 0; m_vg = 0; m_vc = 0; m_ovr = 0; m_rerr = 0;
        end else begin
            m_stb = settled_after(n);
            m_tck = (en_len % DIV) == (DIV - 1);
            m_w   = pad_at(n - 1);
            m_cap = en && m_pending && m_stb;
            if (m_cap && (!m_valid || rdy)) begin
                m_valid = 1;
                m_il = m_w[7:0]; m_vg = m_w[15:8]; m_vc = m_w[23:16];
                m_rerr = (m_il > 7) || (m_il == 0) || (m_vc > 6) || (m_vc == 0);
            end else if (m_cap) begin
                if (m_ovr != 8'd255) m_ovr = m_ovr + 8'd1;
            end else if (m_valid && rdy) begin
                m_valid = 0;
                m_rerr  = 0;
            end
            if (!en) begin
                m_active = 0; m_pending = 0;
            end else if (!m_active) begin
                m_active = 1;
            end else if (!m_pending) begin
                if (m_tck) m_pending = 1;
            end else if (m_stb) begin
                m_pending = 0;
            end
            n = n + 1;
            padh[n % HLEN] = {vc_pad, vg_pad, il_pad};
            en_len = en ? en_len + 1 : 0;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("m_valid", smp_valid, m_valid);
            chk("m_il", il_out, m_il);
            chk("m_vg", vg_out, m_vg);
            chk("m_vc", vc_out, m_vc);
            chk("m_ovr", overrun_cnt, m_ovr);
            chk("m_busy", busy, m_pending);
`ifdef FCS_MPC_SAMPLE_RANGE_CHECK_EN
            chk("m_rerr", range_err, m_rerr);
`endif
        end
    end

    // ---------------- directed + random stimulus ----------------
    task automatic set_pads(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c);
        il_pad = a; vg_pad = b; vc_pad = c;
    endtask

    // Counts rising edges until smp_valid is seen (sampled 1 after each edge).
    task automatic wait_valid(input int budget, output int k);
        k = 0;
        do begin
            @(posedge clk); #1;
            k++;
        end while (!smp_valid && k < budget);
        if (!smp_valid) begin
            total++; bad++;
            $display("FAIL wait_valid: no sample within %0d cycles", budget);
        end
    endtask

`ifdef FCS_MPC_SAMPLE_RANGE_CHECK_EN
    task automatic range_case(input logic [7:0] il, input logic [7:0] vc, input logic exp);
        int k;
        @(negedge clk);
        set_pads(il, 8'h55, vc);
        k = 0;
        do begin
            @(posedge clk); #1;
            k++;
        end while (!(smp_valid && il_out == il && vc_out == vc) && k < 80);
        chk("range_err", range_err, exp);
    endtask
`endif

    initial begin
        int k;
        int hold;
        int en_off;
        logic [7:0] ta, tb;

        set_pads(8'd3, 8'd12, 8'd2);
        repeat (3) @(negedge clk);
        chk_en = 1'b1;
        chk("rst_valid", smp_valid, 0);
        chk("rst_il", il_out, 0);
        chk("rst_ovr", overrun_cnt, 0);
        chk("rst_busy", busy, 0);

        // First sample: enable edge + 16 period cycles + capture edge.
        rst = 1'b0; en = 1'b1;
        wait_valid(100, k);
        chk("first_latency", k, 17);
        chk("first_il", il_out, 3);
        chk("first_vg", vg_out, 12);
        chk("first_vc", vc_out, 2);
        chk("first_ovr", overrun_cnt, 0);

        // Bus never settles while toggling every 2 cycles: request stays pending.
        ta = 8'd100 + 8'($urandom_range(0, 50));
        tb = ta + 8'd1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            rdy = 1'b1;
            if (((i / 2) % 2) == 0) set_pads(tb, tb, tb);
            else                    set_pads(ta, ta, ta);
        end
        chk("toggle_busy", busy, 1);
        chk("toggle_novalid", smp_valid, 0);
        @(negedge clk);
        set_pads(8'd5, 8'd12, 8'd4);
        wait_valid(40, k);
        chk("settle_latency", k, 8);   // change edge, then 2 sync + 4 stable + 1 capture
        chk("settle_il", il_out, 5);
        chk("settle_vg", vg_out, 12);
        chk("settle_vc", vc_out, 4);

        // Stalled consumer: one delivery, then three drops 16 cycles apart.
        @(negedge clk);
        @(posedge clk);
        @(negedge clk);
        rdy = 1'b0;
        wait_valid(40, k);
        @(negedge clk);
        set_pads(8'd9, 8'd33, 8'd3);
        repeat (48) @(posedge clk);
        #1;
        chk("stall_ovr", overrun_cnt, 3);
        chk("stall_valid", smp_valid, 1);
        chk("stall_il", il_out, 5);
        chk("stall_vg", vg_out, 12);
        chk("stall_vc", vc_out, 4);
        @(negedge clk);
        rdy = 1'b1;
        @(posedge clk); #1;
        chk("pulse_drop", smp_valid, 0);
        @(negedge clk);
        rdy = 1'b0;
        wait_valid(30, k);
        chk("next_cap_cycles", k, 15);
        chk("next_cap_il", il_out, 9);

        // Handshake coinciding with a capture: back-to-back, no drop.
        @(negedge clk);
        set_pads(8'd21, 8'd40, 8'd5);
        repeat (15) @(posedge clk);
        @(negedge clk);
        rdy = 1'b1;
        @(posedge clk); #1;
        chk("b2b_valid", smp_valid, 1);
        chk("b2b_il", il_out, 21);
        chk("b2b_vg", vg_out, 40);
        chk("b2b_vc", vc_out, 5);
        chk("b2b_ovr", overrun_cnt, 3);
        @(negedge clk);
        rdy = 1'b0;

        // Reset pulse while a request is pending and a sample is held.
        for (int i = 0; i < 24; i++) begin
            @(negedge clk);
            if (((i / 2) % 2) == 0) set_pads(ta, ta, ta);
            else                    set_pads(tb, tb, tb);
        end
        chk("pre_rst_busy", busy, 1);
        chk("pre_rst_valid", smp_valid, 1);
        @(negedge clk);
        rst = 1'b1;
        set_pads(8'd3, 8'd12, 8'd2);
        @(posedge clk); #1;
        chk("rst_pulse_valid", smp_valid, 0);
        chk("rst_pulse_il", il_out, 0);
        chk("rst_pulse_vg", vg_out, 0);
        chk("rst_pulse_vc", vc_out, 0);
        chk("rst_pulse_ovr", overrun_cnt, 0);
        chk("rst_pulse_busy", busy, 0);
        @(negedge clk);
        rst = 1'b0;
        rdy = 1'b1;
        wait_valid(100, k);
        chk("resume_latency", k, 17);
        chk("resume_il", il_out, 3);

        // Random traffic against the model.
        hold = 0;
        en_off = 0;
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            if (hold == 0) begin
                set_pads(8'($urandom_range(0, 9)), 8'($urandom), 8'($urandom_range(0, 8)));
                hold = $urandom_range(1, 12);
            end
            hold--;
            rdy = ($urandom_range(0, 3) != 0);
            if (en_off > 0) begin
                en_off--;
                en = (en_off == 0);
            end else if ($urandom_range(0, 149) == 0) begin
                en = 1'b0;
                en_off = $urandom_range(1, 20);
            end
            rst = ($urandom_range(0, 799) == 0);
        end
        @(negedge clk);
        rst = 1'b0; en = 1'b1; rdy = 1'b1;

`ifdef FCS_MPC_SAMPLE_RANGE_CHECK_EN
        range_case(8'd8, 8'd1, 1'b1);
        range_case(8'd7, 8'd6, 1'b0);
        range_case(8'd0, 8'd3, 1'b1);
`endif

        repeat (4) @(negedge clk);
        chk_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fcs_mpc_sample_rx.md
Name: fcs_mpc_sample_rx

Overview:
- Receive side of the FCS-MPC sensor input interface on user GPIO.
- Captures the three 8-bit measurement buses from mprj_io: inductor current iL on [16:9], grid voltage vg on [24:17], capacitor voltage vc on [32:25].
- Synchronises, debounces, decimates and frames the buses into coherent samples for the MPC core.
- Sits between the io_in slice of user_project_wrapper and the MPC cost-evaluation engine; hands samples over with a valid/ready handshake.

Parameters:
- SAMPLE_DIV, 16, clock cycles between sample requests; legal range 2..65535.
- STABLE_CYCLES, 4, consecutive unchanged synchronised cycles required before capture; legal range 1..255.
- IL_MAX, 8'd7, upper legal iL code; used only with the optional feature.
- VC_MAX, 8'd6, upper legal vc code; used only with the optional feature.

Ports:
- wb_clk_i  in  1  system clock.
- wb_rst_i  in  1  synchronous reset, active-high.
- en  in  1  block enable; 0 forces IDLE.
- il_pad  in  8  raw iL bus, asynchronous to wb_clk_i.
- vg_pad  in  8  raw vg bus, asynchronous.
- vc_pad  in  8  raw vc bus, asynchronous.
- smp_valid  out  1  sample available.
- smp_ready  in  1  consumer accepts the sample.
- il_out  out  8  captured iL.
- vg_out  out  8  captured vg.
- vc_out  out  8  captured vc.
- overrun_cnt  out  8  count of dropped samples, saturating.
- busy  out  1  high while a sample request is pending (WAIT_STABLE).

Behaviour:
- Reset values:
  - smp_valid=0; il_out, vg_out, vc_out = 0; overrun_cnt=0; busy=0.
  - Synchroniser flops, stability counter and period counter = 0.
  - State = IDLE.
- Synchroniser:
  - Two flops per bit on all 24 bits.
  - word = {vc, vg, il} taken from stage 2.
- Stability counter stab:
  - If word != word delayed one cycle, stab=0; otherwise stab increments, saturating at STABLE_CYCLES.
  - stable = (stab == STABLE_CYCLES).
  - The counter runs regardless of en.
- Period counter:
  - Runs only when en=1; counts 0..SAMPLE_DIV-1 and wraps.
  - tick = (count == SAMPLE_DIV-1).
  - When en=0 the counter is held at 0.
- FSM:
  - IDLE: go to WAIT_TICK when en=1.
  - WAIT_TICK: on tick, go to WAIT_STABLE.
  - WAIT_STABLE: busy=1. When stable, perform a capture attempt and go to WAIT_TICK.
  - From any state, en=0 returns the FSM to IDLE next cycle. A pending request is abandoned. A sample already held in the output register is kept.
  - A tick that occurs while in WAIT_STABLE is ignored; it does not stack a second request.
- Capture attempt:
  - If smp_valid=0, or smp_valid=1 and smp_ready=1 in the same cycle: load the outputs from word and set smp_valid=1 next cycle. A simultaneous handshake and capture yields a back-to-back sample with no bubble.
  - Otherwise (smp_valid=1 and smp_ready=0): the sample is dropped, the held outputs are unchanged, and overrun_cnt increments, saturating at 255.
- Handshake:
  - smp_valid=1 and smp_ready=1 with no capture in the same cycle clears smp_valid next cycle.
  - Outputs stay stable while smp_valid=1 and smp_ready=0.
- Minimum latency, pad change to smp_valid: 2 synchroniser cycles + STABLE_CYCLES + 1 capture cycle, provided a request is already pending.
- wb_rst_i mid-operation: all state returns to reset values in the next cycle; any held sample is lost.

Optional Feature:
- Macro: FCS_MPC_SAMPLE_RANGE_CHECK_EN.
- With the macro defined:
  - Adds output range_err (1 bit), registered together with the sample outputs.
  - range_err=1 when the captured il > IL_MAX, il == 0, vc > VC_MAX, or vc == 0.
  - The sample is still delivered.
  - range_err clears when smp_valid clears.
  - Reset value 0.
- Without the macro: no range_err port and no comparators; the block is otherwise identical.

Test Plan:
- Reset then en=1; pads il=3, vg=12, vc=2 held constant → first smp_valid at cycle 16+1 after en; outputs {il=3, vg=12, vc=2}; overrun_cnt=0.
- Pads toggled every 2 cycles for 40 cycles, then held at il=5, vg=12, vc=4 → busy=1 throughout the toggling, no capture; capture 2+4+1 cycles after the final change with values 5/12/4.
- smp_ready held 0 for 64 cycles with constant pads → one sample delivered, then overrun_cnt=3; outputs unchanged. smp_ready=1 for one cycle → smp_valid drops, or reloads if it coincides with a capture.
- smp_ready=1 on the same cycle as a capture → smp_valid stays 1, new values presented the next cycle, overrun_cnt unchanged.
- wb_rst_i pulsed for 1 cycle while in WAIT_STABLE with smp_valid=1 → all outputs 0 next cycle; normal sampling resumes 16 cycles after release.
- With FCS_MPC_SAMPLE_RANGE_CHECK_EN defined: il=8, vc=1 → range_err=1; il=7, vc=6 → range_err=0; il=0 → range_err=1.
